// File: rtl/spk_train_gen.sv
// Rate encoder: spreads an 8-bit spike count evenly over a 2^WIN_LOG2-beat window
// as thermometer-coded spikes on NUM parallel lanes.
module spk_train_gen #(
  parameter int NUM      = 8,
  parameter int WIN_LOG2 = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [7:0]     cnt_in,
  output logic [NUM-1:0] spk_out,
  output logic           spk_valid,
  output logic           win_done,
  output logic           sat
);

  localparam int SW = WIN_LOG2 + 9;
  localparam logic [31:0] CAP = 32'(NUM << WIN_LOG2);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  localparam logic [WIN_LOG2-1:0] LAST_BEAT = {WIN_LOG2{1'b1}};

  logic [0:0]          state_r;
  logic [7:0]          cnt_r;
  logic [WIN_LOG2-1:0] acc_r;
  logic [WIN_LOG2-1:0] beat_r;
  logic [NUM-1:0]      spk_r;
  logic                spk_valid_r;
  logic                win_done_r;
  logic                sat_r;
  logic [SW-1:0]       sum_s;
  logic [SW-1:0]       k_s;
  logic                sat_s;
  logic [7:0]          cnt_clip_s;

  function automatic logic [NUM-1:0] thermo(input logic [SW-1:0] k);
    logic [NUM-1:0] t;
    t = {NUM{1'b0}};
    for (int i = 0; i < NUM; i++) begin
      t[i] = (k > SW'(i));
    end
    return t;
  endfunction

  // When clipping applies the cap is below 256, so it fits the 8-bit count.
  assign sat_s      = ({24'd0, cnt_in} > CAP);
  assign cnt_clip_s = sat_s ? CAP[7:0] : cnt_in;
  assign sum_s      = SW'(acc_r) + SW'(cnt_r);
  assign k_s        = sum_s >> WIN_LOG2;

  assign in_ready  = (state_r == IDLE);
  assign spk_out   = spk_r;
  assign spk_valid = spk_valid_r;
  assign win_done  = win_done_r;
  assign sat       = sat_r;

  // Window sequencer: accept a count, then emit one beat per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      acc_r       <= {WIN_LOG2{1'b0}};
      beat_r      <= {WIN_LOG2{1'b0}};
      spk_r       <= {NUM{1'b0}};
      spk_valid_r <= 1'b0;
      win_done_r  <= 1'b0;
      sat_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          spk_r       <= {NUM{1'b0}};
          spk_valid_r <= 1'b0;
          win_done_r  <= 1'b0;
          if (in_valid) begin
            cnt_r   <= cnt_clip_s;
            sat_r   <= sat_s;
            acc_r   <= {WIN_LOG2{1'b0}};
            beat_r  <= {WIN_LOG2{1'b0}};
            state_r <= RUN;
          end
        end
        RUN: begin
          acc_r       <= sum_s[WIN_LOG2-1:0];
          spk_r       <= thermo(k_s);
          spk_valid_r <= 1'b1;
          beat_r      <= beat_r + WIN_LOG2'(1);
          win_done_r  <= (beat_r == LAST_BEAT);
          if (beat_r == LAST_BEAT) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          spk_r       <= {NUM{1'b0}};
          spk_valid_r <= 1'b0;
          win_done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spk_train_gen.sv
// Scoreboard bench for spk_train_gen: default instance (NUM=8) and a NUM=4 instance.
module tb_spk_train_gen;

  typedef struct packed {
    logic [7:0] spk;
    logic       wd;
    logic       sat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       in_valid_a = 1'b0;
  logic [7:0] cnt_in_a = 8'd0;
  logic       in_ready_a;
  logic [7:0] spk_out_a;
  logic       spk_valid_a, win_done_a, sat_a;

  logic       in_valid_b = 1'b0;
  logic [7:0] cnt_in_b = 8'd0;
  logic       in_ready_b;
  logic [3:0] spk_out_b;
  logic       spk_valid_b, win_done_b, sat_b;

  int n_checks = 0;
  int n_fail = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int sum_a = 0, beats_a = 0, last_sum_a = -1, last_beats_a = -1, wd_cnt_a = 0;
  int sum_b = 0, beats_b = 0, last_sum_b = -1, last_beats_b = -1;

  spk_train_gen #(.NUM(8), .WIN_LOG2(5)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .cnt_in(cnt_in_a), .spk_out(spk_out_a), .spk_valid(spk_valid_a),
    .win_done(win_done_a), .sat(sat_a)
  );

  spk_train_gen #(.NUM(4), .WIN_LOG2(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .cnt_in(cnt_in_b), .spk_out(spk_out_b), .spk_valid(spk_valid_b),
    .win_done(win_done_b), .sat(sat_b)
  );

  always #5 clk = ~clk;

  // Expected beat i carries floor((i+1)c/32) - floor(ic/32) spikes as a thermometer.
  task automatic push_window(input int num, input int cnt, input bit to_b);
    int c;
    int n;
    logic [8:0] t;
    exp_t e;
    c = (cnt > num * 32) ? num * 32 : cnt;
    for (int i = 0; i < 32; i++) begin
      n = ((i + 1) * c) / 32 - (i * c) / 32;
      t = (9'd1 << n) - 9'd1;
      e.spk = t[7:0];
      e.wd  = (i == 31);
      e.sat = (cnt > num * 32);
      if (to_b) q_b.push_back(e);
      else q_a.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (spk_valid_a) begin
        n_checks++;
        if (q_a.size() == 0) begin
          n_fail++;
          $display("FAIL sb_a_extra_beat: got spk=%h with no expected beat", spk_out_a);
        end else begin
          ea = q_a.pop_front();
          if ({spk_out_a, win_done_a, sat_a} !== {ea.spk, ea.wd, ea.sat}) begin
            n_fail++;
            $display("FAIL sb_a_beat: got spk=%h wd=%b sat=%b, want spk=%h wd=%b sat=%b",
                     spk_out_a, win_done_a, sat_a, ea.spk, ea.wd, ea.sat);
          end
        end
        sum_a += $countones(spk_out_a);
        beats_a++;
        if (win_done_a) begin
          last_sum_a = sum_a;
          last_beats_a = beats_a;
          wd_cnt_a++;
          sum_a = 0;
          beats_a = 0;
        end
      end else begin
        sum_a = 0;
        beats_a = 0;
        n_checks++;
        if (spk_out_a !== 8'd0 || win_done_a !== 1'b0) begin
          n_fail++;
          $display("FAIL sb_a_idle: got spk=%h wd=%b, want 00 0", spk_out_a, win_done_a);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && spk_valid_b) begin
      n_checks++;
      if (q_b.size() == 0) begin
        n_fail++;
        $display("FAIL sb_b_extra_beat: got spk=%h with no expected beat", spk_out_b);
      end else begin
        eb = q_b.pop_front();
        if ({4'd0, spk_out_b, win_done_b, sat_b} !== {eb.spk, eb.wd, eb.sat}) begin
          n_fail++;
          $display("FAIL sb_b_beat: got spk=%h wd=%b sat=%b, want spk=%h wd=%b sat=%b",
                   spk_out_b, win_done_b, sat_b, eb.spk, eb.wd, eb.sat);
        end
      end
      sum_b += $countones(spk_out_b);
      beats_b++;
      if (win_done_b) begin
        last_sum_b = sum_b;
        last_beats_b = beats_b;
        sum_b = 0;
        beats_b = 0;
      end
    end else if (rst_n) begin
      sum_b = 0;
      beats_b = 0;
    end
  end

  task automatic accept_a(input int cnt);
    @(negedge clk);
    for (int i = 0; i < 200 && in_ready_a !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if (in_ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_a_ready: got in_ready=%b, want 1", in_ready_a);
    end
    in_valid_a = 1'b1;
    cnt_in_a = 8'(cnt);
    push_window(8, cnt, 1'b0);
    @(posedge clk);
    #1 in_valid_a = 1'b0;
  endtask

  task automatic wait_empty_a(input string name);
    for (int i = 0; i < 200 && q_a.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (q_a.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d beats outstanding, want 0", name, q_a.size());
      q_a.delete();
    end
  endtask

  task automatic check_window_a(input string name, input int want_sum);
    n_checks++;
    if (last_sum_a != want_sum || last_beats_a != 32) begin
      n_fail++;
      $display("FAIL %s_total: got sum=%0d beats=%0d, want sum=%0d beats=32",
               name, last_sum_a, last_beats_a, want_sum);
    end
  endtask

  task automatic run_window_a(input string name, input int cnt);
    accept_a(cnt);
    wait_empty_a(name);
    check_window_a(name, cnt);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({spk_out_a, spk_valid_a, win_done_a, sat_a, in_ready_a} !== {8'd0, 4'b0001}) begin
      n_fail++;
      $display("FAIL reset_a: got spk=%h v=%b wd=%b sat=%b rdy=%b, want 00 0 0 0 1",
               spk_out_a, spk_valid_a, win_done_a, sat_a, in_ready_a);
    end
    n_checks++;
    if ({spk_out_b, spk_valid_b, win_done_b, sat_b, in_ready_b} !== {4'd0, 4'b0001}) begin
      n_fail++;
      $display("FAIL reset_b: got spk=%h v=%b wd=%b sat=%b rdy=%b, want 0 0 0 0 1",
               spk_out_b, spk_valid_b, win_done_b, sat_b, in_ready_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_patterns;
    run_window_a("cnt0", 0);
    run_window_a("cnt32", 32);
    run_window_a("cnt1", 1);
    run_window_a("cnt16", 16);
    run_window_a("cnt255", 255);
  endtask

  task automatic test_hold_valid;
    @(negedge clk);
    in_valid_a = 1'b1;
    cnt_in_a = 8'd5;
    push_window(8, 5, 1'b0);
    @(posedge clk);
    #1 cnt_in_a = 8'd200;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready_a !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_ready_run: got in_ready=%b, want 0", in_ready_a);
      end
    end
    for (int i = 0; i < 100 && win_done_a !== 1'b1; i++) @(negedge clk);
    in_valid_a = 1'b0;
    wait_empty_a("hold");
    check_window_a("hold", 5);
  endtask

  task automatic test_back_to_back;
    accept_a(40);
    for (int i = 0; i < 100 && win_done_a !== 1'b1; i++) @(negedge clk);
    n_checks++;
    if (win_done_a !== 1'b1 || in_ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_last_beat: got wd=%b rdy=%b, want 1 1", win_done_a, in_ready_a);
    end
    in_valid_a = 1'b1;
    cnt_in_a = 8'd3;
    push_window(8, 3, 1'b0);
    @(posedge clk);
    #1 in_valid_a = 1'b0;
    @(negedge clk);
    n_checks++;
    if (spk_valid_a !== 1'b0 || in_ready_a !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_gap: got valid=%b rdy=%b, want 0 0", spk_valid_a, in_ready_a);
    end
    @(negedge clk);
    n_checks++;
    if (spk_valid_a !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_start: got valid=%b, want 1", spk_valid_a);
    end
    wait_empty_a("b2b");
    check_window_a("b2b", 3);
  endtask

  task automatic test_num4;
    @(negedge clk);
    in_valid_b = 1'b1;
    cnt_in_b = 8'd200;
    push_window(4, 200, 1'b1);
    @(posedge clk);
    #1 in_valid_b = 1'b0;
    for (int i = 0; i < 200 && q_b.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (q_b.size() != 0 || last_sum_b != 128 || last_beats_b != 32) begin
      n_fail++;
      $display("FAIL num4_total: got sum=%0d beats=%0d left=%0d, want 128 32 0",
               last_sum_b, last_beats_b, q_b.size());
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (sat_b !== 1'b1 || spk_valid_b !== 1'b0) begin
      n_fail++;
      $display("FAIL num4_sat_hold: got sat=%b valid=%b, want 1 0", sat_b, spk_valid_b);
    end
  endtask

  task automatic test_mid_reset;
    int wd0;
    accept_a(100);
    repeat (10) @(negedge clk);
    wd0 = wd_cnt_a;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    q_a.delete();
    n_checks++;
    if ({spk_out_a, spk_valid_a, win_done_a, sat_a, in_ready_a} !== {8'd0, 4'b0001}) begin
      n_fail++;
      $display("FAIL midrst_a: got spk=%h v=%b wd=%b sat=%b rdy=%b, want 00 0 0 0 1",
               spk_out_a, spk_valid_a, win_done_a, sat_a, in_ready_a);
    end
    n_checks++;
    if (sat_b !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_sat_b: got sat=%b, want 0", sat_b);
    end
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    n_checks++;
    if (wd_cnt_a != wd0 || spk_valid_a !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_no_done: got win_done count=%0d valid=%b, want %0d 0",
               wd_cnt_a, spk_valid_a, wd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_patterns();
    test_hold_valid();
    test_back_to_back();
    test_num4();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
